// File: rtl/io_serdes_rx_align.sv
// rtl/io_serdes_rx_align.sv - multi-lane serial deserializer with training-pattern frame alignment and word FIFO
module io_serdes_rx_align #(
  parameter int unsigned           pLANES         = 12,
  parameter int unsigned           pCLK_RATIO     = 4,
  parameter int unsigned           pFIFO_DEPTH    = 4,
  parameter logic [pCLK_RATIO-1:0] pTRAIN_PATTERN = 4'b0001,
  parameter int unsigned           pLOCK_COUNT    = 8
) (
  input  logic                               ioclk,
  input  logic                               io_rst,
  input  logic                               rx_en,
  input  logic [pLANES-1:0]                  serial_rxd,
  output logic [pLANES*pCLK_RATIO-1:0]       word_data,
  output logic                               word_valid,
  input  logic                               word_ready,
  output logic                               locked,
  output logic [$clog2(pCLK_RATIO)-1:0]      align_phase,
  output logic                               overflow,
  output logic [$clog2(pFIFO_DEPTH):0]       fifo_level
);

  localparam int unsigned WW = pLANES * pCLK_RATIO;
  localparam int unsigned PW = $clog2(pCLK_RATIO);
  localparam int unsigned AW = $clog2(pFIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned CW = $clog2(pLOCK_COUNT + 1);
  localparam logic [LW-1:0] FULL_LVL = LW'(pFIFO_DEPTH);
  localparam logic [CW-1:0] LOCK_CNT = CW'(pLOCK_COUNT);

  typedef enum logic [1:0] {ST_IDLE, ST_HUNT, ST_VERIFY, ST_LOCKED} state_t;

  state_t          state_q, state_d;
  logic [WW-1:0]   sr_q;
  logic [PW-1:0]   ph_q;
  logic [PW-1:0]   align_q, align_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            push_q, push_d;
  logic [WW-1:0]   word_q;
  logic [WW-1:0]   mem_q [pFIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]   lvl_q;
  logic            ovf_q;
  logic            lane0_match, all_match, boundary;
  logic            pop, full, wr_en;

  assign lane0_match = (sr_q[pCLK_RATIO-1:0] == pTRAIN_PATTERN);
  assign boundary    = (ph_q == align_q);

  // Every lane currently holds the training/idle symbol
  always_comb begin
    all_match = 1'b1;
    for (int i = 0; i < int'(pLANES); i++) begin
      if (sr_q[i*pCLK_RATIO +: pCLK_RATIO] != pTRAIN_PATTERN) all_match = 1'b0;
    end
  end

  // Per-lane shift registers (newest bit at MSB) and free-running frame phase
  always_ff @(posedge ioclk) begin
    if (io_rst) begin
      sr_q <= '0;
      ph_q <= '0;
    end else if (rx_en) begin
      for (int i = 0; i < int'(pLANES); i++) begin
        sr_q[i*pCLK_RATIO +: pCLK_RATIO] <= {serial_rxd[i], sr_q[i*pCLK_RATIO+1 +: pCLK_RATIO-1]};
      end
      ph_q <= ph_q + 1'b1;
    end else begin
      ph_q <= '0;
    end
  end

  // Alignment FSM next state; also decides whether this boundary yields a data word
  always_comb begin
    state_d = state_q;
    align_d = align_q;
    cnt_d   = cnt_q;
    push_d  = 1'b0;
    case (state_q)
      ST_IDLE: state_d = ST_HUNT;
      ST_HUNT: begin
        if (lane0_match) begin
          align_d = ph_q;
          cnt_d   = CW'(1);
          state_d = ST_VERIFY;
        end
      end
      ST_VERIFY: begin
        if (boundary) begin
          if (all_match) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q + 1'b1 >= LOCK_CNT) state_d = ST_LOCKED;
          end else begin
            cnt_d   = '0;
            state_d = ST_HUNT;
          end
        end
      end
      ST_LOCKED: push_d = boundary && !all_match;
      default:   state_d = ST_IDLE;
    endcase
    if (!rx_en) begin
      state_d = ST_IDLE;
      align_d = '0;
      cnt_d   = '0;
      push_d  = 1'b0;
    end
  end

  // FSM registers plus one-stage holding register for the assembled word
  always_ff @(posedge ioclk) begin
    if (io_rst) begin
      state_q <= ST_IDLE;
      align_q <= '0;
      cnt_q   <= '0;
      push_q  <= 1'b0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      align_q <= align_d;
      cnt_q   <= cnt_d;
      push_q  <= push_d;
      if (push_d) word_q <= sr_q;
    end
  end

  assign pop   = (lvl_q != '0) && word_ready;
  assign full  = (lvl_q == FULL_LVL);
  assign wr_en = push_q && (!full || pop);

  // Show-ahead word FIFO; a push into a full FIFO without a pop is dropped and flagged
  always_ff @(posedge ioclk) begin
    if (io_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      lvl_q    <= '0;
      ovf_q    <= 1'b0;
      for (int i = 0; i < int'(pFIFO_DEPTH); i++) mem_q[i] <= '0;
    end else if (!rx_en) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      lvl_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (wr_en) begin
        mem_q[wr_ptr_q] <= word_q;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_q && !wr_en) ovf_q <= 1'b1;
      case ({wr_en, pop})
        2'b10:   lvl_q <= lvl_q + 1'b1;
        2'b01:   lvl_q <= lvl_q - 1'b1;
        default: lvl_q <= lvl_q;
      endcase
    end
  end

  assign word_data   = mem_q[rd_ptr_q];
  assign word_valid  = (lvl_q != '0);
  assign locked      = (state_q == ST_LOCKED);
  assign align_phase = align_q;
  assign overflow    = ovf_q;
  assign fifo_level  = lvl_q;

endmodule

// File: tb/tb_io_serdes_rx_align.sv
// tb/tb_io_serdes_rx_align.sv - randomized bench with behavioural aligner/FIFO reference model
module tb_io_serdes_rx_align;
  localparam int L = 12, R = 4, W = 48, D = 4, LOCKN = 8;
  localparam logic [R-1:0] PAT = 4'b0001;

  logic          ioclk = 1'b0;
  logic          io_rst = 1'b1, rx_en = 1'b0, word_ready = 1'b0;
  logic [L-1:0]  serial_rxd = '0;
  logic [W-1:0]  word_data;
  logic          word_valid, locked, overflow;
  logic [1:0]    align_phase;
  logic [2:0]    fifo_level;

  io_serdes_rx_align dut (
    .ioclk(ioclk), .io_rst(io_rst), .rx_en(rx_en), .serial_rxd(serial_rxd),
    .word_data(word_data), .word_valid(word_valid), .word_ready(word_ready),
    .locked(locked), .align_phase(align_phase), .overflow(overflow), .fifo_level(fifo_level)
  );

  always #5 ioclk = ~ioclk;

  int total = 0, bad = 0, cyc = 0;
  always @(posedge ioclk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] train_word();
    logic [W-1:0] w;
    for (int i = 0; i < L; i++) w[i*R +: R] = PAT;
    return w;
  endfunction

  // ---------------- reference model ----------------
  // mode: 0 idle, 1 hunting, 2 verifying, 3 locked
  logic [L-1:0] hist[$];
  int           m_mode = 0, m_ph = 0, m_align = 0, m_cnt = 0;
  bit           m_pend = 0, m_ovf = 0;
  logic [W-1:0] m_pend_w;
  logic [W-1:0] m_q[$];

  task automatic model_reset();
    hist.delete();
    repeat (R) hist.push_back('0);
    m_mode = 0; m_ph = 0; m_align = 0; m_cnt = 0;
    m_pend = 0; m_ovf = 0; m_q.delete();
  endtask

  // frame bit k of lane i = k-th of the last R bits seen on that lane
  function automatic logic [W-1:0] frame_now();
    logic [W-1:0] f;
    for (int i = 0; i < L; i++)
      for (int k = 0; k < R; k++) f[i*R+k] = hist[k][i];
    return f;
  endfunction

  task automatic model_step();
    logic [W-1:0] fr, dummy;
    bit l0, allm, bnd, pop, npend;
    if (io_rst) begin model_reset(); return; end
    if (!rx_en) begin
      m_mode = 0; m_ph = 0; m_align = 0; m_cnt = 0;
      m_q.delete(); m_ovf = 0; m_pend = 0;
      return;
    end
    fr    = frame_now();
    l0    = (fr[R-1:0] == PAT);
    allm  = (fr == train_word());
    bnd   = (m_ph == m_align);
    pop   = (m_q.size() > 0) && word_ready;
    npend = (m_mode == 3) && bnd && !allm;
    if (pop) dummy = m_q.pop_front();
    if (m_pend) begin
      if (m_q.size() < D) m_q.push_back(m_pend_w);
      else m_ovf = 1;
    end
    case (m_mode)
      0: m_mode = 1;
      1: if (l0) begin m_align = m_ph; m_cnt = 1; m_mode = 2; end
      2: if (bnd) begin
           if (allm) begin m_cnt++; if (m_cnt >= LOCKN) m_mode = 3; end
           else begin m_cnt = 0; m_mode = 1; end
         end
      default: ;
    endcase
    m_pend   = npend;
    m_pend_w = fr;
    m_ph     = (m_ph + 1) % R;
    hist.push_back(serial_rxd);
    dummy = {{(W-L){1'b0}}, hist.pop_front()};
  endtask

  always @(posedge ioclk) model_step();

  // per-cycle comparison against the model
  always @(negedge ioclk) begin
    if (cyc > 0) begin
      chk("locked", 64'(locked), 64'(m_mode == 3));
      chk("align_phase", 64'(align_phase), 64'(m_align));
      chk("word_valid", 64'(word_valid), 64'(m_q.size() > 0));
      chk("fifo_level", 64'(fifo_level), 64'(m_q.size()));
      chk("overflow", 64'(overflow), 64'(m_ovf));
      if (m_q.size() > 0) chk("word_data", 64'(word_data), 64'(m_q[0]));
    end
  end

  // ---------------- stimulus ----------------
  bit           rx_cmd = 0, rst_cmd = 1, gen_on = 0, rnd_ready = 0, cur_data = 0;
  int           j = 0, off = 0, pending = 0, last_edge = 0;
  logic [W-1:0] cur;
  logic [W-1:0] fq[$];
  logic [W-1:0] g[5];

  task automatic cycle();
    int k;
    @(negedge ioclk);
    io_rst = rst_cmd;
    rx_en  = rx_cmd;
    if (rnd_ready) word_ready = ($urandom_range(0, 1) == 1);
    if (rx_cmd && gen_on) begin
      k = (j + R - off) % R;
      if (k == 0) begin
        if (fq.size() > 0) begin cur = fq.pop_front(); cur_data = 1; end
        else begin cur = train_word(); cur_data = 0; end
      end
      for (int i = 0; i < L; i++) serial_rxd[i] = cur[i*R+k];
      if (k == R-1 && cur_data) begin pending--; last_edge = cyc + 1; end
      j++;
    end else begin
      serial_rxd = L'($urandom);
    end
  endtask

  task automatic restart(input int o);
    rx_cmd = 1; gen_on = 1; j = 0; off = o;
    cur = train_word(); cur_data = 0; fq.delete(); pending = 0;
  endtask

  task automatic send_wait();
    for (int t = 0; pending > 0 && t < 2000; t++) cycle();
    chk("send_done", 64'(pending), 64'd0);
  endtask

  task automatic run_to_j(input int target);
    for (int t = 0; j < target && t < 5000; t++) cycle();
    chk("run_to_j", 64'(j), 64'(target));
  endtask

  function automatic logic [W-1:0] rnd_word();
    logic [W-1:0] w;
    w = W'({$urandom(), $urandom()});
    w[3:0] = 4'hF;
    return w;
  endfunction

  initial begin
    logic [W-1:0] nib;
    model_reset();
    // reset values
    repeat (3) cycle();
    chk("rst_valid", 64'(word_valid), 64'd0);
    chk("rst_locked", 64'(locked), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_level", 64'(fifo_level), 64'd0);
    chk("rst_align", 64'(align_phase), 64'd0);
    chk("rst_data", 64'(word_data), 64'd0);
    rst_cmd = 0;
    cycle();

    // training stream at phase 2: lock after 8 frames, idle words discarded
    restart(2);
    run_to_j(35);
    chk("lock_early", 64'(locked), 64'd0);
    cycle();
    chk("lock_at8", 64'(locked), 64'd1);
    chk("align2", 64'(align_phase), 64'd2);
    repeat (20) cycle();
    chk("idle_discard", 64'(word_valid), 64'd0);

    // lane i carries nibble i
    nib = 48'hBA9876543210;
    fq.push_back(nib); pending = 1;
    send_wait();
    for (int t = 0; t < 10; t++) begin cycle(); if (word_valid) break; end
    chk("nib_valid", 64'(word_valid), 64'd1);
    chk("nib_latency", 64'(cyc), 64'(last_edge + 2));
    chk("nib_data", 64'(word_data), 64'h0000BA9876543210);
    word_ready = 1; cycle(); word_ready = 0; cycle();

    // five words into a 4-deep FIFO with no consumer
    for (int n = 0; n < 5; n++) begin g[n] = rnd_word(); fq.push_back(g[n]); end
    pending = 5;
    send_wait();
    repeat (4) cycle();
    chk("full_level", 64'(fifo_level), 64'd4);
    chk("full_ovf", 64'(overflow), 64'd1);
    chk("full_head", 64'(word_data), 64'(g[0]));
    word_ready = 1;
    for (int n = 0; n < 4; n++) begin
      chk("drain_order", 64'(word_data), 64'(g[n]));
      cycle();
    end
    word_ready = 0;
    chk("drain_level", 64'(fifo_level), 64'd0);
    chk("ovf_sticky", 64'(overflow), 64'd1);

    // rx_en drop with 3 buffered words
    for (int n = 0; n < 3; n++) fq.push_back(rnd_word());
    pending = 3;
    send_wait();
    repeat (3) cycle();
    chk("buf3", 64'(fifo_level), 64'd3);
    rx_cmd = 0; cycle(); cycle();
    chk("drop_level", 64'(fifo_level), 64'd0);
    chk("drop_locked", 64'(locked), 64'd0);
    chk("drop_ovf", 64'(overflow), 64'd0);

    // phase 1, lane 7 corrupted in the frame checked at count 5
    restart(1);
    for (int n = 0; n < 5; n++) fq.push_back(train_word());
    nib = train_word();
    nib[7*R +: R] = 4'b0011;
    fq.push_back(nib);
    pending = 6;
    send_wait();
    chk("corrupt_nolock", 64'(locked), 64'd0);
    run_to_j(58);
    chk("relock_early", 64'(locked), 64'd0);
    cycle();
    chk("relock", 64'(locked), 64'd1);
    chk("align1", 64'(align_phase), 64'd1);

    // full FIFO, push coincides with pop
    for (int n = 0; n < 4; n++) begin g[n] = rnd_word(); fq.push_back(g[n]); end
    pending = 4;
    send_wait();
    repeat (3) cycle();
    chk("fill4", 64'(fifo_level), 64'd4);
    g[4] = rnd_word(); fq.push_back(g[4]); pending = 1;
    send_wait();
    cycle(); cycle();
    word_ready = 1; cycle(); word_ready = 0;
    chk("pushpop_level", 64'(fifo_level), 64'd4);
    chk("pushpop_ovf", 64'(overflow), 64'd0);
    chk("pushpop_head", 64'(word_data), 64'(g[1]));

    // random episodes: random phase, random data/idle mix, random consumer, occasional reset
    for (int ep = 0; ep < 8; ep++) begin
      rx_cmd = 0; cycle();
      restart($urandom_range(0, R-1));
      for (int t = 0; t < 120 && m_mode != 3; t++) cycle();
      chk("ep_lock", 64'(locked), 64'd1);
      rnd_ready = 1;
      pending = $urandom_range(1, 9);
      for (int n = 0; n < pending; n++)
        fq.push_back(($urandom_range(0, 3) == 0) ? train_word() : rnd_word());
      send_wait();
      repeat ($urandom_range(0, 8)) cycle();
      if (ep % 3 == 2) begin
        rst_cmd = 1; cycle(); rst_cmd = 0; cycle();
        chk("ep_rst_level", 64'(fifo_level), 64'd0);
        chk("ep_rst_locked", 64'(locked), 64'd0);
        repeat (30) cycle();
      end
      rnd_ready = 0; word_ready = 0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/io_serdes_rx_align.md
IO_SERDES_RX_ALIGN -- requirements
Module: io_serdes_rx_align

Interface
REQ-001 Parameter pLANES, default 12, number of serial lanes.
REQ-002 Parameter pCLK_RATIO, default 4, bits per lane per frame; power of two, 2..16.
REQ-003 Parameter pFIFO_DEPTH, default 4, word FIFO entries; power of two, >=2.
REQ-004 Parameter pTRAIN_PATTERN, default 4'b0001, pCLK_RATIO-bit training/idle symbol; all rotations distinct.
REQ-005 Parameter pLOCK_COUNT, default 8, consecutive good training frames required for lock.
REQ-006 ioclk  input  1  sole clock; all state updates on rising edge.
REQ-007 io_rst  input  1  reset; synchronous, active-high.
REQ-008 rx_en  input  1  receive enable; low forces IDLE.
REQ-009 serial_rxd  input  pLANES  one bit per lane per ioclk.
REQ-010 word_data  output  pLANES*pCLK_RATIO  FIFO head word.
REQ-011 word_valid  output  1  FIFO not empty.
REQ-012 word_ready  input  1  consumer accept; pop on word_valid&&word_ready.
REQ-013 locked  output  1  high in LOCKED state only.
REQ-014 align_phase  output  $clog2(pCLK_RATIO)  captured frame phase.
REQ-015 overflow  output  1  sticky: word dropped on full FIFO.
REQ-016 fifo_level  output  $clog2(pFIFO_DEPTH)+1  current occupancy.

Function
REQ-017 Each lane SHALL shift serial_rxd[i] into a pCLK_RATIO-bit register every cycle rx_en=1; newest bit enters MSB.
REQ-018 Frame bit ordering SHALL be: word_data[i*pCLK_RATIO+k] = k-th bit received on lane i within the frame (k=0 first).
REQ-019 A free-running phase counter SHALL increment modulo pCLK_RATIO every cycle rx_en=1; cleared when rx_en=0.
REQ-020 FSM states SHALL be IDLE, HUNT, VERIFY, LOCKED.
REQ-021 IDLE -> HUNT on rx_en=1; any state -> IDLE on rx_en=0 (same edge), flushing FIFO and clearing overflow, lock counter, align_phase.
REQ-022 HUNT: on the first cycle lane 0 shift register equals pTRAIN_PATTERN, SHALL capture phase counter into align_phase, set lock counter=1, go VERIFY.
REQ-023 VERIFY: on each cycle phase counter == align_phase, all lanes equal to pTRAIN_PATTERN SHALL increment lock counter; any lane mismatch SHALL return to HUNT with lock counter=0.
REQ-024 VERIFY -> LOCKED on the boundary where lock counter reaches pLOCK_COUNT; locked asserts the following cycle.
REQ-025 LOCKED: on each boundary cycle, the assembled word SHALL be pushed to the FIFO unless every lane equals pTRAIN_PATTERN (idle word, discarded).
REQ-026 LOCKED SHALL persist until rx_en=0 or io_rst; data content never drops lock.
REQ-027 Latency: word_valid SHALL assert exactly 2 rising edges after the edge sampling the frame's last bit, when FIFO was empty and word_ready=0.
REQ-028 FIFO SHALL be show-ahead: word_data valid combinationally from head whenever word_valid=1; word_data undefined-free (holds last head) otherwise.
REQ-029 Push when full without same-cycle pop SHALL drop the new word, keep contents, set overflow.
REQ-030 Push and pop in the same cycle when full SHALL both succeed; level unchanged.
REQ-031 Push and pop in the same cycle when empty: push only (pop ignored since word_valid=0).
REQ-032 Read/write pointers SHALL wrap modulo pFIFO_DEPTH; fifo_level SHALL reach pFIFO_DEPTH exactly.
REQ-033 overflow SHALL remain set until io_rst or rx_en=0.

Reset
REQ-034 io_rst=1 at a rising edge SHALL force: state IDLE, all shift registers 0, phase counter 0, align_phase 0, lock counter 0, FIFO empty.
REQ-035 Output reset values: word_valid=0, locked=0, overflow=0, fifo_level=0, align_phase=0, word_data=0.
REQ-036 io_rst mid-frame or mid-LOCKED SHALL discard partial frames and buffered words; io_rst has priority over rx_en.

Verification
REQ-037 Defaults, rx_en=1, all lanes send 0001 continuously starting phase 2 -> align_phase=2, locked=1 after 8 verified frames, word_valid stays 0 (idle discarded).
REQ-038 Locked, lane i sends nibble i (LSB first) for one frame -> word_data=48'hBA9876543210, word_valid 2 edges after last bit.
REQ-039 Locked, word_ready=0, 5 distinct data frames -> fifo_level=4, overflow=1, head = first word; then ready=1 -> 4 words in order.
REQ-040 VERIFY at count 5, lane 7 corrupted one frame -> return to HUNT, locked=0, relock requires 8 fresh frames.
REQ-041 Full FIFO with word_ready=1 on push cycle -> no overflow, fifo_level stays 4.
REQ-042 rx_en dropped while LOCKED with 3 words buffered -> next cycle IDLE, fifo_level=0, locked=0, overflow=0.
